sap_control_sequencer: RTL and testbench

- Microcoded control sequencer for the 8-bit bus computer.
- Issues the active-low load/output strobes that drive the bus registers. Those registers load from the bus on n_load and drive it on n_out; this block is the initiator that sequences them.
- Steps a fetch/execute microstep counter, decodes the 4-bit opcode from the instruction register and the carry/zero flags, and emits one 16-bit control word per clock.
- Sits between the instruction register/flags register and every bus participant: PC, MAR, RAM, A, B, ALU and OUT.

---
 rtl/sap_control_sequencer_if.sv | 22 ++
 rtl/sap_control_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_control_sequencer_if.sv
// Bus between the control sequencer and the rest of the 8-bit computer:
// instruction/flag inputs, run control, and the control word fan-out.
interface sap_control_sequencer_if;
    logic        step_en;   // advance enable (single-step/run control)
    logic [3:0]  opcode;    // upper nibble of the instruction register
    logic        flag_c;    // registered carry flag
    logic        flag_z;    // registered zero flag
    logic [15:0] ctrl;      // control word to every bus participant
    logic [2:0]  step;      // current microstep, T0 = 0
    logic        halted;    // high once HLT has executed

    // The sequencer initiates every bus transfer, so it is the master.
    modport master (
        input  step_en, opcode, flag_c, flag_z,
        output ctrl, step, halted
    );

    modport slave (
        output step_en, opcode, flag_c, flag_z,
        input  ctrl, step, halted
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// Microcoded control sequencer: steps the fetch/execute microstep counter and
// decodes opcode, flags and step into one 16-bit control word per clock.
module sap_control_sequencer #(
    parameter int EARLY_END = 1,  // 1: skip trailing empty microsteps
    parameter int NUM_STEPS = 5   // microsteps per instruction, 3..8
) (
    input logic                       clk,
    input logic                       rst_n,
    sap_control_sequencer_if.master   bus
);

    // Word with every strobe deasserted (active-low bits high).
    localparam logic [15:0] CTRL_IDLE = 16'h6DFE;
    localparam logic [2:0]  STEP_LAST = 3'(NUM_STEPS - 1);

    // Each constant is the bit that flips away from CTRL_IDLE when the
    // signal is asserted, so XOR works for both polarities alike.
    localparam logic [15:0] C_HLT = 16'h0001;
    localparam logic [15:0] C_MI  = 16'h0002;
    localparam logic [15:0] C_RI  = 16'h0004;
    localparam logic [15:0] C_RO  = 16'h0008;
    localparam logic [15:0] C_IO  = 16'h0010;
    localparam logic [15:0] C_II  = 16'h0020;
    localparam logic [15:0] C_AI  = 16'h0040;
    localparam logic [15:0] C_AO  = 16'h0080;
    localparam logic [15:0] C_EO  = 16'h0100;
    localparam logic [15:0] C_SU  = 16'h0200;
    localparam logic [15:0] C_BI  = 16'h0400;
    localparam logic [15:0] C_OI  = 16'h0800;
    localparam logic [15:0] C_CE  = 16'h1000;
    localparam logic [15:0] C_CO  = 16'h2000;
    localparam logic [15:0] C_J   = 16'h4000;
    localparam logic [15:0] C_FI  = 16'h8000;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_STA = 4'd4,
        OP_LDI = 4'd5,
        OP_JMP = 4'd6,
        OP_JC  = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } opcode_e;

    logic [2:0]  r_step;
    logic        r_halted;
    logic [2:0]  w_step_nxt;
    logic        w_halted_nxt;
    logic [15:0] w_assert;     // signals asserted in the current step
    logic [2:0]  w_last_busy;  // last microstep that carries microcode
    logic        w_early_end;
    logic        w_t2;
    logic        w_t3;
    logic        w_t4;

    // State register: microstep counter and halt latch.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step   <= 3'd0;
            r_halted <= 1'b0;
        end else begin
            r_step   <= w_step_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Microcode decode: asserted signals and last busy step for this opcode.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_assert    = '0;
        w_last_busy = 3'd1;
        w_t2        = (r_step == 3'd2);
        w_t3        = (r_step == 3'd3);
        w_t4        = (r_step == 3'd4);

        // Fetch is opcode-independent; II in T1 updates opcode for T2 on.
        case (r_step)
            3'd0:    w_assert = C_CO | C_MI;
            3'd1:    w_assert = C_RO | C_II | C_CE;
            default: w_assert = '0;
        endcase

        case (bus.opcode)
            OP_LDA: begin
                w_last_busy = 3'd3;
                if (w_t2) w_assert = C_IO | C_MI;
                if (w_t3) w_assert = C_RO | C_AI;
            end
            OP_ADD, OP_SUB: begin
                w_last_busy = 3'd4;
                if (w_t2) w_assert = C_IO | C_MI;
                if (w_t3) w_assert = C_RO | C_BI;
                if (w_t4) w_assert = C_EO | C_AI | C_FI
                                   | ((bus.opcode == OP_SUB) ? C_SU : 16'h0000);
            end
            OP_STA: begin
                w_last_busy = 3'd3;
                if (w_t2) w_assert = C_IO | C_MI;
                if (w_t3) w_assert = C_AO | C_RI;
            end
            OP_LDI: begin
                w_last_busy = 3'd2;
                if (w_t2) w_assert = C_IO | C_AI;
            end
            OP_JMP: begin
                w_last_busy = 3'd2;
                if (w_t2) w_assert = C_IO | C_J;
            end
            OP_JC: begin
                // A jump not taken leaves T2 empty, so early end applies there.
                w_last_busy = bus.flag_c ? 3'd2 : 3'd1;
                if (w_t2 && bus.flag_c) w_assert = C_IO | C_J;
            end
            OP_JZ: begin
                w_last_busy = bus.flag_z ? 3'd2 : 3'd1;
                if (w_t2 && bus.flag_z) w_assert = C_IO | C_J;
            end
            OP_OUT: begin
                w_last_busy = 3'd2;
                if (w_t2) w_assert = C_AO | C_OI;
            end
            OP_HLT: begin
                w_last_busy = 3'd2;
                if (w_t2) w_assert = C_HLT;
            end
            default: w_last_busy = 3'd1;  // NOP and unused opcodes 9..13
        endcase

        w_early_end = (EARLY_END != 0) && (r_step >= 3'd2) && (r_step >= w_last_busy);
    end

    // Next-state: advance, wrap or early-end the step; HLT at T2 halts.
    always_comb begin
        w_step_nxt   = r_step;
        w_halted_nxt = r_halted;
        if (bus.step_en && !r_halted) begin
            if (w_t2 && (bus.opcode == OP_HLT)) begin
                w_halted_nxt = 1'b1;
                w_step_nxt   = 3'd0;
            end else if ((r_step == STEP_LAST) || w_early_end) begin
                w_step_nxt   = 3'd0;
            end else begin
                w_step_nxt   = r_step + 3'd1;
            end
        end
    end

    // Control word: idle while in reset, HLT-only while halted, else decode.
    always_comb begin
        if (!rst_n) begin
            bus.ctrl = CTRL_IDLE;
        end else if (r_halted) begin
            bus.ctrl = CTRL_IDLE | C_HLT;
        end else begin
            bus.ctrl = CTRL_IDLE ^ w_assert;
        end
    end

    assign bus.step   = r_step;
    assign bus.halted = r_halted;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: two instances (early end on and
// off) share clock, reset and stimulus; expected words are queued as the
// stimulus is applied and compared when the outputs are sampled.
module tb_sap_control_sequencer;

    localparam logic [15:0] W_IDLE  = 16'h6DFE;
    localparam logic [15:0] W_HALT  = 16'h6DFF;  // idle + HLT
    localparam logic [15:0] W_T0    = 16'h4DFC;  // CO MI
    localparam logic [15:0] W_T1    = 16'h7DD6;  // RO II CE
    localparam logic [15:0] W_IO_MI = 16'h6DEC;
    localparam logic [15:0] W_RO_AI = 16'h6DB6;
    localparam logic [15:0] W_RO_BI = 16'h69F6;
    localparam logic [15:0] W_ADD4  = 16'hECBE;  // EO AI FI
    localparam logic [15:0] W_SUB4  = 16'hEEBE;  // EO AI FI SU
    localparam logic [15:0] W_AO_RI = 16'h6D7A;
    localparam logic [15:0] W_IO_AI = 16'h6DAE;
    localparam logic [15:0] W_IO_J  = 16'h2DEE;
    localparam logic [15:0] W_AO_OI = 16'h657E;
    localparam logic [15:0] DRV_MASK = 16'h2198;  // RO IO AO EO CO

    typedef struct {
        string       tag;
        bit          on_b;    // 0: early-end instance, 1: full-length instance
        logic [2:0]  step;
        logic [15:0] ctrl;
        logic        halted;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] t2;
        bit          has_t3;
        logic [15:0] t3;
    } instr_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    exp_t sb_q[$];

    sap_control_sequencer_if if_a ();
    sap_control_sequencer_if if_b ();

    sap_control_sequencer #(.EARLY_END(1), .NUM_STEPS(5)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    sap_control_sequencer #(.EARLY_END(0), .NUM_STEPS(5)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // At most one bus driver may be enabled in any step.
    always @(negedge clk) begin
        check("one_driver_a", 32'($countones(~if_a.ctrl & DRV_MASK) <= 1), 32'd1);
        check("one_driver_b", 32'($countones(~if_b.ctrl & DRV_MASK) <= 1), 32'd1);
    end

    task automatic set_in(input logic en, input logic [3:0] op, input logic c, input logic z);
        if_a.step_en = en;  if_b.step_en = en;
        if_a.opcode  = op;  if_b.opcode  = op;
        if_a.flag_c  = c;   if_b.flag_c  = c;
        if_a.flag_z  = z;   if_b.flag_z  = z;
    endtask

    task automatic exp_a(input string tag, input logic [2:0] s, input logic [15:0] c,
                         input logic h = 1'b0);
        exp_t e;
        e.tag = tag; e.on_b = 1'b0; e.step = s; e.ctrl = c; e.halted = h;
        sb_q.push_back(e);
    endtask

    task automatic exp_b(input string tag, input logic [2:0] s, input logic [15:0] c,
                         input logic h = 1'b0);
        exp_t e;
        e.tag = tag; e.on_b = 1'b1; e.step = s; e.ctrl = c; e.halted = h;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then drain the scoreboard.
    task automatic check_now();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.on_b) begin
                check({e.tag, "_b_ctrl"},   32'(if_b.ctrl),   32'(e.ctrl));
                check({e.tag, "_b_step"},   32'(if_b.step),   32'(e.step));
                check({e.tag, "_b_halted"}, 32'(if_b.halted), 32'(e.halted));
            end else begin
                check({e.tag, "_a_ctrl"},   32'(if_a.ctrl),   32'(e.ctrl));
                check({e.tag, "_a_step"},   32'(if_a.step),   32'(e.step));
                check({e.tag, "_a_halted"}, 32'(if_a.halted), 32'(e.halted));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        check_now();
        tick();
    endtask

    // Hold reset across one rising edge, checking the idle word, then release.
    task automatic apply_reset();
        rst_n = 1'b0;
        exp_a("rst", 3'd0, W_IDLE);
        exp_b("rst", 3'd0, W_IDLE);
        check_now();
        tick();
        rst_n = 1'b1;
    endtask

    instr_t tbl[7];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        set_in(1'b1, 4'd0, 1'b0, 1'b0);
        @(negedge clk);

        // NOP with early end: T2 is empty and the last step, so wrap after it.
        apply_reset();
        exp_a("nop_t0", 3'd0, W_T0);   cycle();
        exp_a("nop_t1", 3'd1, W_T1);   cycle();
        exp_a("nop_t2", 3'd2, W_IDLE); cycle();
        exp_a("nop_wrap", 3'd0, W_T0); check_now();

        // LDA on both instances; only the full-length one visits T4.
        set_in(1'b1, 4'd1, 1'b0, 1'b0);
        apply_reset();
        exp_a("lda_t0", 3'd0, W_T0);    exp_b("lda_t0", 3'd0, W_T0);    cycle();
        exp_a("lda_t1", 3'd1, W_T1);    exp_b("lda_t1", 3'd1, W_T1);    cycle();
        exp_a("lda_t2", 3'd2, W_IO_MI); exp_b("lda_t2", 3'd2, W_IO_MI); cycle();
        exp_a("lda_t3", 3'd3, W_RO_AI); exp_b("lda_t3", 3'd3, W_RO_AI); cycle();
        exp_a("lda_wrap", 3'd0, W_T0);  exp_b("lda_t4", 3'd4, W_IDLE);  cycle();
        exp_b("lda_wrap", 3'd0, W_T0);  check_now();

        // SUB: SU only in T4.
        set_in(1'b1, 4'd3, 1'b0, 1'b0);
        apply_reset();
        exp_a("sub_t0", 3'd0, W_T0);    cycle();
        exp_a("sub_t1", 3'd1, W_T1);    cycle();
        exp_a("sub_t2", 3'd2, W_IO_MI); cycle();
        exp_a("sub_t3", 3'd3, W_RO_BI); cycle();
        exp_a("sub_t4", 3'd4, W_SUB4);  cycle();
        exp_a("sub_wrap", 3'd0, W_T0);  check_now();

        // JC not taken, then taken, then carry drops mid-T2.
        set_in(1'b1, 4'd7, 1'b0, 1'b0);
        apply_reset();
        exp_a("jc0_t0", 3'd0, W_T0);   cycle();
        exp_a("jc0_t1", 3'd1, W_T1);   cycle();
        exp_a("jc0_t2", 3'd2, W_IDLE); cycle();
        set_in(1'b1, 4'd7, 1'b1, 1'b0);
        exp_a("jc1_t0", 3'd0, W_T0);   cycle();
        exp_a("jc1_t1", 3'd1, W_T1);   cycle();
        exp_a("jc1_t2", 3'd2, W_IO_J); check_now();
        set_in(1'b1, 4'd7, 1'b0, 1'b0);
        exp_a("jc_flag_drop", 3'd2, W_IDLE); cycle();
        exp_a("jc_wrap", 3'd0, W_T0);  check_now();

        // Single-instruction table on the early-end instance.
        tbl[0] = '{op: 4'd4,  c: 1'b0, z: 1'b0, t2: W_IO_MI, has_t3: 1'b1, t3: W_AO_RI};
        tbl[1] = '{op: 4'd5,  c: 1'b0, z: 1'b0, t2: W_IO_AI, has_t3: 1'b0, t3: W_IDLE};
        tbl[2] = '{op: 4'd6,  c: 1'b0, z: 1'b0, t2: W_IO_J,  has_t3: 1'b0, t3: W_IDLE};
        tbl[3] = '{op: 4'd8,  c: 1'b0, z: 1'b1, t2: W_IO_J,  has_t3: 1'b0, t3: W_IDLE};
        tbl[4] = '{op: 4'd8,  c: 1'b1, z: 1'b0, t2: W_IDLE,  has_t3: 1'b0, t3: W_IDLE};
        tbl[5] = '{op: 4'd14, c: 1'b0, z: 1'b0, t2: W_AO_OI, has_t3: 1'b0, t3: W_IDLE};
        tbl[6] = '{op: 4'd11, c: 1'b1, z: 1'b1, t2: W_IDLE,  has_t3: 1'b0, t3: W_IDLE};
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, tbl[i].op, tbl[i].c, tbl[i].z);
            apply_reset();
            exp_a($sformatf("op%0d_t0", tbl[i].op), 3'd0, W_T0);     cycle();
            exp_a($sformatf("op%0d_t1", tbl[i].op), 3'd1, W_T1);     cycle();
            exp_a($sformatf("op%0d_t2", tbl[i].op), 3'd2, tbl[i].t2); cycle();
            if (tbl[i].has_t3) begin
                exp_a($sformatf("op%0d_t3", tbl[i].op), 3'd3, tbl[i].t3); cycle();
            end
            exp_a($sformatf("op%0d_wrap", tbl[i].op), 3'd0, W_T0);  check_now();
        end

        // ADD: freeze in T3 for three cycles, then reset mid-T3.
        set_in(1'b1, 4'd2, 1'b0, 1'b0);
        apply_reset();
        exp_a("add_t0", 3'd0, W_T0);    cycle();
        exp_a("add_t1", 3'd1, W_T1);    cycle();
        exp_a("add_t2", 3'd2, W_IO_MI); cycle();
        exp_a("add_t3", 3'd3, W_RO_BI); check_now();
        set_in(1'b0, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_a($sformatf("add_hold%0d", i), 3'd3, W_RO_BI);
            check_now();
        end
        rst_n = 1'b0;
        exp_a("add_rst_mid", 3'd0, W_IDLE); check_now();
        tick();
        rst_n = 1'b1;
        set_in(1'b1, 4'd2, 1'b0, 1'b0);
        exp_a("add_resume_t0", 3'd0, W_T0); check_now();

        // ADD T4 word on the full-length instance after a fresh start.
        apply_reset();
        tick(); tick(); tick(); tick();
        exp_b("add_t4", 3'd4, W_ADD4);  check_now();

        // HLT on both instances: halts on the edge ending T2, then sticks.
        set_in(1'b1, 4'd15, 1'b0, 1'b0);
        apply_reset();
        exp_a("hlt_t0", 3'd0, W_T0); exp_b("hlt_t0", 3'd0, W_T0); cycle();
        exp_a("hlt_t1", 3'd1, W_T1); exp_b("hlt_t1", 3'd1, W_T1); cycle();
        exp_a("hlt_t2", 3'd2, W_HALT, 1'b0); exp_b("hlt_t2", 3'd2, W_HALT, 1'b0); cycle();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) set_in(1'b1, 4'd1, 1'b1, 1'b1);
            exp_a($sformatf("halt%0d", i), 3'd0, W_HALT, 1'b1);
            exp_b($sformatf("halt%0d", i), 3'd0, W_HALT, 1'b1);
            cycle();
        end
        rst_n = 1'b0;
        exp_a("hlt_rst", 3'd0, W_IDLE, 1'b0); exp_b("hlt_rst", 3'd0, W_IDLE, 1'b0);
        check_now();
        tick();
        rst_n = 1'b1;
        exp_a("hlt_after_t0", 3'd0, W_T0, 1'b0); cycle();
        exp_a("hlt_after_t1", 3'd1, W_T1, 1'b0); check_now();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    // Run-time bound: the stimulus above is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule
